// File: rtl/dds_param_control.sv
// dds_param_control: run-time phase/amplitude/shape control for the DDS datapath,
// with pulse-driven user adjustment and an autonomous triangular frequency sweep.
module dds_param_control #(
  parameter int unsigned PHASE_W    = 11,
  parameter int unsigned AMP_W      = 11,
  parameter int unsigned AMP_MAX    = 2047,
  parameter int unsigned PHASE_DEF  = 500,
  parameter int unsigned AMP_DEF    = 1200,
  parameter int unsigned SHAPE_DEF  = 0,
  parameter int unsigned NUM_SHAPES = 3,
  parameter int unsigned SWEEP_DIV  = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_field,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic [1:0]         step_sel,
  input  logic               sweep_en,
  input  logic [PHASE_W-1:0] sweep_lo,
  input  logic [PHASE_W-1:0] sweep_hi,
  output logic [1:0]         field,
  output logic [PHASE_W-1:0] phase_M,
  output logic [AMP_W-1:0]   signal_A,
  output logic [1:0]         signal_shape,
  output logic               cfg_upd
);

  localparam int unsigned PW = PHASE_W + 1;
  localparam int unsigned AW = AMP_W + 1;
  localparam int unsigned CW = (SWEEP_DIV > 2) ? $clog2(SWEEP_DIV) : 1;
  localparam logic [PW-1:0] PH_MAX = {1'b0, {PHASE_W{1'b1}}};
  localparam logic [AW-1:0] A_MAX  = AW'(AMP_MAX);
  localparam logic [CW-1:0] P_LAST = CW'(SWEEP_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RAMP_UP = 2'd1, RAMP_DN = 2'd2} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      presc, presc_n;
  logic               sweep_en_q;
  logic [1:0]         field_n;
  logic [PHASE_W-1:0] phase_n;
  logic [AMP_W-1:0]   amp_n;
  logic [1:0]         shape_n;
  logic               cfg_upd_n;

  // Step sizes and one-bit-wider operands so over/underflow is seen before clamping.
  logic [3:0]    sh_amt;
  logic [PW-1:0] step_p, ph_w, lo_w, hi_w, ph_sum, ph_dif, lo_plus;
  logic [AW-1:0] step_a, a_w, a_sum, a_dif;
  logic          sweep_rise, tick, adj;

  assign sh_amt     = 4'(step_sel) * 4'd3;
  assign step_p     = PW'(1) << sh_amt;
  assign step_a     = AW'(1) << sh_amt;
  assign ph_w       = {1'b0, phase_M};
  assign lo_w       = {1'b0, sweep_lo};
  assign hi_w       = {1'b0, sweep_hi};
  assign ph_sum     = ph_w + step_p;
  assign ph_dif     = ph_w - step_p;
  assign lo_plus    = lo_w + step_p;
  assign a_w        = {1'b0, signal_A};
  assign a_sum      = a_w + step_a;
  assign a_dif      = a_w - step_a;
  assign sweep_rise = sweep_en & ~sweep_en_q;
  assign tick       = (state != IDLE) && (presc == P_LAST);
  assign adj        = btn_up ^ btn_down;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      presc        <= '0;
      sweep_en_q   <= 1'b0;
      field        <= 2'd0;
      phase_M      <= PHASE_W'(PHASE_DEF);
      signal_A     <= AMP_W'(AMP_DEF);
      signal_shape <= 2'(SHAPE_DEF);
      cfg_upd      <= 1'b0;
    end else begin
      state        <= state_n;
      presc        <= presc_n;
      sweep_en_q   <= sweep_en;
      field        <= field_n;
      phase_M      <= phase_n;
      signal_A     <= amp_n;
      signal_shape <= shape_n;
      cfg_upd      <= cfg_upd_n;
    end
  end

  // Next-state: sweep FSM, user adjustment, field select and update strobe.
  always_comb begin
    state_n = state;
    presc_n = presc;
    field_n = field;
    phase_n = phase_M;
    amp_n   = signal_A;
    shape_n = signal_shape;

    if (sweep_rise) begin
      phase_n = sweep_lo;
      presc_n = '0;
      state_n = RAMP_UP;
    end else if (!sweep_en) begin
      state_n = IDLE;
      presc_n = '0;
    end else if (state != IDLE) begin
      presc_n = tick ? '0 : presc + CW'(1);
      if (tick) begin
        if (sweep_lo >= sweep_hi) begin
          phase_n = sweep_lo;
        end else if (state == RAMP_UP) begin
          if (ph_sum >= hi_w) begin
            phase_n = sweep_hi;
            state_n = RAMP_DN;
          end else begin
            phase_n = ph_sum[PHASE_W-1:0];
          end
        end else begin
          if (ph_w <= lo_plus) begin
            phase_n = sweep_lo;
            state_n = RAMP_UP;
          end else begin
            phase_n = ph_dif[PHASE_W-1:0];
          end
        end
      end
    end

    if (adj) begin
      case (field)
        2'd0: begin
          if (!sweep_en) begin
            if (btn_up) phase_n = (ph_sum > PH_MAX) ? PH_MAX[PHASE_W-1:0] : ph_sum[PHASE_W-1:0];
            else        phase_n = (ph_w <= step_p) ? PHASE_W'(1) : ph_dif[PHASE_W-1:0];
          end
        end
        2'd1: begin
          if (btn_up) amp_n = (a_sum > A_MAX) ? A_MAX[AMP_W-1:0] : a_sum[AMP_W-1:0];
          else        amp_n = (a_w < step_a) ? '0 : a_dif[AMP_W-1:0];
        end
        2'd2: begin
          if (btn_up) shape_n = (signal_shape >= 2'(NUM_SHAPES - 1)) ? 2'd0 : signal_shape + 2'd1;
          else        shape_n = (signal_shape == 2'd0) ? 2'(NUM_SHAPES - 1) : signal_shape - 2'd1;
        end
        default: ;
      endcase
    end

    if (btn_field) field_n = (field == 2'd2) ? 2'd0 : field + 2'd1;

    cfg_upd_n = (phase_n != phase_M) || (amp_n != signal_A) || (shape_n != signal_shape);
  end

endmodule

// File: tb/tb_dds_param_control.sv
// Testbench for dds_param_control: directed scenarios plus random stimulus,
// each cycle's expected outputs queued by a reference model and checked by a monitor.
module tb_dds_param_control;

  localparam int DIV  = 4;
  localparam int PMAX = 2047;
  localparam int AMAX = 2047;
  localparam int NS   = 3;

  typedef struct packed {
    logic [1:0]  fld;
    logic [10:0] ph;
    logic [10:0] amp;
    logic [1:0]  sh;
    logic        cfg;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_field, btn_up, btn_down;
  logic [1:0]  step_sel;
  logic        sweep_en;
  logic [10:0] sweep_lo, sweep_hi;
  logic [1:0]  field;
  logic [10:0] phase_M;
  logic [10:0] signal_A;
  logic [1:0]  signal_shape;
  logic        cfg_upd;

  int checks = 0;
  int failures = 0;
  obs_t exp_q[$];

  // Reference model state, kept in plain integers.
  int m_ph, m_amp, m_sh, m_fld, m_cnt;
  bit m_sweep, m_up, m_en_prev;

  dds_param_control #(.SWEEP_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .btn_field(btn_field), .btn_up(btn_up), .btn_down(btn_down),
    .step_sel(step_sel), .sweep_en(sweep_en), .sweep_lo(sweep_lo), .sweep_hi(sweep_hi),
    .field(field), .phase_M(phase_M), .signal_A(signal_A), .signal_shape(signal_shape),
    .cfg_upd(cfg_upd)
  );

  always #5 clk = ~clk;

  function automatic int clamp(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic obs_t cur_obs();
    obs_t o;
    o.fld = field; o.ph = phase_M; o.amp = signal_A; o.sh = signal_shape; o.cfg = cfg_upd;
    return o;
  endfunction

  task automatic report(string name, obs_t act, obs_t expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got field=%0d phase=%0d amp=%0d shape=%0d upd=%0d, expected field=%0d phase=%0d amp=%0d shape=%0d upd=%0d",
               name, act.fld, act.ph, act.amp, act.sh, act.cfg, expv.fld, expv.ph, expv.amp, expv.sh, expv.cfg);
    end
  endtask

  task automatic model_reset();
    m_ph = 500; m_amp = 1200; m_sh = 0; m_fld = 0; m_cnt = 0;
    m_sweep = 0; m_up = 1; m_en_prev = 0;
  endtask

  function automatic obs_t defaults();
    obs_t o;
    o.fld = 2'd0; o.ph = 11'd500; o.amp = 11'd1200; o.sh = 2'd0; o.cfg = 1'b0;
    return o;
  endfunction

  // Apply the current inputs for one clock edge and queue what the outputs must become.
  task automatic model_step();
    int step, nph, namp, nsh, lo, hi;
    obs_t e;
    step = 1 << (3 * int'(step_sel));
    lo = int'(sweep_lo); hi = int'(sweep_hi);
    nph = m_ph; namp = m_amp; nsh = m_sh;
    if (sweep_en && !m_en_prev) begin
      nph = lo; m_sweep = 1; m_up = 1; m_cnt = 0;
    end else if (!sweep_en) begin
      m_sweep = 0; m_cnt = 0;
    end else if (m_sweep) begin
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        if (lo >= hi) nph = lo;
        else if (m_up) begin
          if (m_ph + step >= hi) begin nph = hi; m_up = 0; end
          else nph = m_ph + step;
        end else begin
          if (m_ph - step <= lo) begin nph = lo; m_up = 1; end
          else nph = m_ph - step;
        end
      end else m_cnt++;
    end
    if (btn_up != btn_down) begin
      case (m_fld)
        0: if (!sweep_en) nph = clamp(m_ph + (btn_up ? step : -step), 1, PMAX);
        1: namp = clamp(m_amp + (btn_up ? step : -step), 0, AMAX);
        2: nsh = (m_sh + (btn_up ? 1 : NS - 1)) % NS;
        default: ;
      endcase
    end
    if (btn_field) m_fld = (m_fld + 1) % 3;
    e.cfg = (nph != m_ph) || (namp != m_amp) || (nsh != m_sh);
    m_ph = nph; m_amp = namp; m_sh = nsh; m_en_prev = sweep_en;
    e.fld = 2'(m_fld); e.ph = 11'(m_ph); e.amp = 11'(m_amp); e.sh = 2'(m_sh);
    exp_q.push_back(e);
  endtask

  // Drive buttons for one cycle (from a negedge), queue the expectation, wait to next negedge.
  task automatic cyc(input bit f, input bit u, input bit d);
    btn_field = f; btn_up = u; btn_down = d;
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  // Monitor: compare the DUT against the queued expectation after every edge.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        report("cycle", cur_obs(), e);
      end
    end
  end

  initial begin
    rst = 1'b1; btn_field = 0; btn_up = 0; btn_down = 0;
    step_sel = 2'd3; sweep_en = 0; sweep_lo = '0; sweep_hi = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 report("reset", cur_obs(), defaults());
    @(negedge clk);
    rst = 1'b0;

    // FREQ saturation at both ends.
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0);
    // AMP saturation and simultaneous up/down.
    cyc(1, 0, 0);
    step_sel = 2'd2;
    for (int i = 0; i < 14; i++) cyc(0, 1, 0);
    cyc(0, 1, 1);
    cyc(0, 0, 1);
    // SHAPE wrap both directions, then field advance with an adjustment.
    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(1, 1, 0);
    // Sweep 10..30 step 8, FREQ adjustment ignored while sweeping.
    step_sel = 2'd1; sweep_lo = 11'd10; sweep_hi = 11'd30; sweep_en = 1;
    idle(10);
    cyc(0, 1, 0);
    idle(20);
    sweep_en = 0;
    idle(3);
    cyc(0, 1, 0);
    sweep_en = 1;
    idle(9);
    // Async reset mid-sweep, between edges.
    #2 rst = 1'b1;
    #1 report("async_reset", cur_obs(), defaults());
    model_reset();
    sweep_en = 0;
    @(negedge clk);
    rst = 1'b0;
    // Degenerate bounds.
    sweep_lo = 11'd40; sweep_hi = 11'd40; sweep_en = 1;
    idle(20);
    sweep_en = 0;
    idle(2);

    // Random stimulus.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) sweep_en = ~sweep_en;
      if ($urandom_range(0, 29) == 0) begin
        sweep_lo = 11'($urandom_range(0, 2047));
        sweep_hi = ($urandom_range(0, 5) == 0) ? sweep_lo : 11'($urandom_range(0, 2047));
      end
      step_sel = 2'($urandom_range(0, 3));
      cyc(bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 2) == 0),
          bit'($urandom_range(0, 2) == 0));
    end
    idle(1);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dds_param_control.md
Name: dds_param_control

Overview:
- Parametrised run-time control unit for the DDS datapath. Generates the phase increment, amplitude and waveform-shape words consumed by the phase accumulator, ROM lookup and amplitude scaler.
- Adds user adjustment via single-cycle pulse inputs: field select, up/down with selectable step, saturation and shape wrap.
- Adds an autonomous frequency-sweep mode with a programmable rate.
- Emits a one-cycle update strobe whenever any output changes.

Parameters:
- PHASE_W, 11: width of phase_M.
- AMP_W, 11: width of signal_A.
- AMP_MAX, 2047: upper saturation limit for signal_A.
- PHASE_DEF, 500: phase_M value loaded at reset.
- AMP_DEF, 1200: signal_A value loaded at reset.
- SHAPE_DEF, 0: signal_shape value loaded at reset. Encoding: 0 sin, 1 triangle, 2 square.
- NUM_SHAPES, 3: number of legal shape codes, range 2..4.
- SWEEP_DIV, 100000: clock cycles per sweep step, ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- btn_field  in  1  pulse: advance selected field FREQ → AMP → SHAPE → FREQ.
- btn_up  in  1  pulse: increment the selected field.
- btn_down  in  1  pulse: decrement the selected field.
- step_sel  in  2  step size = 1 << (3*step_sel), giving 1, 8, 64 or 512.
- sweep_en  in  1  level: enables frequency sweep.
- sweep_lo  in  PHASE_W  sweep lower bound.
- sweep_hi  in  PHASE_W  sweep upper bound.
- field  out  2  current field: 0 FREQ, 1 AMP, 2 SHAPE.
- phase_M  out  PHASE_W  phase increment.
- signal_A  out  AMP_W  amplitude.
- signal_shape  out  2  waveform select.
- cfg_upd  out  1  one-cycle pulse, asserted the cycle after any of phase_M, signal_A or signal_shape changes value.

Behaviour:
- Reset (async assert, released synchronously by the environment):
  - phase_M = PHASE_DEF, signal_A = AMP_DEF, signal_shape = SHAPE_DEF, field = 0, cfg_upd = 0.
  - Sweep FSM = IDLE, prescaler = 0, sweep_en history register = 0.
  - Reset mid-sweep aborts the sweep immediately.
- Latency: every input pulse takes effect on registered outputs at the next clk edge.
- btn_up and btn_down high in the same cycle: both are ignored.
- btn_field concurrent with up/down: the up/down applies to the old field; field advances on the same edge. btn_field wraps 2 → 0.
- FREQ field, up/down: phase_M ± step, saturating to [1, 2^PHASE_W−1]. The result is never 0 and never wraps.
- AMP field, up/down: signal_A ± step, saturating to [0, AMP_MAX].
- SHAPE field: step is ignored. Up = (s+1) mod NUM_SHAPES; down = (s+NUM_SHAPES−1) mod NUM_SHAPES.
- Sweep FSM states: IDLE, RAMP_UP, RAMP_DN.
  - Entering: a sweep_en rising edge (detected against the registered previous value) loads phase_M = sweep_lo, clears the prescaler and moves to RAMP_UP. Transition is from any state.
  - Ticking: in RAMP_*, the prescaler counts 0..SWEEP_DIV−1; a tick occurs when it reaches SWEEP_DIV−1, and the prescaler then returns to 0.
  - RAMP_UP tick: phase_M += step. If the result is ≥ sweep_hi, phase_M = sweep_hi and the FSM moves to RAMP_DN.
  - RAMP_DN tick: phase_M −= step. If the result is ≤ sweep_lo, phase_M = sweep_lo and the FSM moves to RAMP_UP.
  - Arithmetic is carried out one bit wider than PHASE_W so that overflow and underflow are detected before clamping.
  - Degenerate bounds: if sweep_lo ≥ sweep_hi, phase_M is held at sweep_lo with no ramp and no cfg_upd after entry.
  - Bounds are sampled at each tick; changes mid-sweep take effect at the next tick.
- While sweep_en = 1, FREQ-field up/down is ignored. AMP and SHAPE adjustment still operate.
- sweep_en falling: FSM goes to IDLE; phase_M holds its current value.
- cfg_upd is not asserted when a saturated operation leaves the value unchanged.

Test Plan:
- Reset, then release → phase_M=500, signal_A=1200, signal_shape=0, field=0, cfg_upd=0.
- field=FREQ, step_sel=3, phase_M=500: btn_down → 1 (saturated); btn_down again → 1 and no cfg_upd; btn_up ×4 → 2047 (saturated).
- field=AMP, step_sel=2 (step 64): btn_up ×14 from 1200 → 2047. btn_up and btn_down in the same cycle → no change.
- field=SHAPE: btn_up ×3 from 0 → 1, 2, 0; btn_down → 2. btn_field with btn_up at field=2 → shape changes and field=0.
- SWEEP_DIV=4, step_sel=1, sweep_lo=10, sweep_hi=30, sweep_en rising → phase_M=10, then 18, 26, 30 (→RAMP_DN), 22, 14, 10 (→RAMP_UP), each 4 cycles apart. FREQ btn_up is ignored during the sweep.
- Async rst asserted mid-sweep, between clock edges → outputs return to their defaults immediately. sweep_lo=sweep_hi=40 → phase_M stays 40 with no further cfg_upd.
